mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS datapath. Sits directly downstream of the ALU decoder: consumes its ALUControl codes 9 (mult), 12 (multu), 10 (div) and 13 (divu), runs a 32-iteration shift-add or restoring-divide sequence, and writes the 64-bit result into HI/LO. The control FSM stalls on Busy. mfhi/mflo read HI/LO directly, and mthi/mtlo write them.

## Interface
- DATA_width, 32: operand and HI/LO width.
- ALUControl_width, 5: width of the ALU control code input.
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-low reset.
- Start  in  1  one-cycle request; sampled with ALUControl, SrcA and SrcB.
- ALUControl  in  ALUControl_width  operation code from the ALU decoder.
- SrcA  in  DATA_width  dividend / multiplicand, or mthi/mtlo data.
- SrcB  in  DATA_width  divisor / multiplier.
- MTHI  in  1  write SrcA into HI.
- MTLO  in  1  write SrcA into LO.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse when HI/LO have just been updated by an operation.
- HI  out  DATA_width  HI register (mult upper word / div remainder).
- LO  out  DATA_width  LO register (mult lower word / div quotient).

## Operation
- FSM states: IDLE, CALC, FIX.
- **IDLE**
  - Start is accepted only with ALUControl ∈ {9, 10, 12, 13}; any other code is ignored.
  - On accept:
    - Latch the operands.
    - For signed codes (9, 10), latch absolute values and record result signs: product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA.
    - Clear the 6-bit iteration counter and go to CALC.
- **CALC**
  - One iteration per cycle, 32 cycles (counter 0..31), then go to FIX.
  - Multiply: test multiplier LSB, conditionally add the multiplicand into the upper 33-bit accumulator, then shift the accumulator/multiplier pair right one bit.
  - Divide: shift the remainder:quotient pair left, trial-subtract the divisor, restore on negative, set the quotient bit.
- **FIX**
  - Apply two's-complement sign correction, write HI/LO, assert Done, go to IDLE.
- **Divide by zero** (SrcB = 0, either div code): LO = 32'hFFFFFFFF, HI = SrcA as sampled. Full latency, Done asserted.
- **Signed overflow** (div, 32'h80000000 / 32'hFFFFFFFF): LO = 32'h80000000, HI = 0.
- **mthi/mtlo**
  - MTHI/MTLO in IDLE write SrcA to HI/LO at the next edge. Both may be asserted together.
  - Ignored while Busy.
  - If Start is accepted in the same cycle, Start wins and MTHI/MTLO are ignored.
- Start while Busy is ignored; the in-flight operation is unaffected.
- HI/LO hold their value except on an FIX write, an accepted MTHI/MTLO, or reset.

## Timing
- Reset values: Busy = 0, Done = 0, HI = 0, LO = 0, state = IDLE, counter = 0.
- Reset asserted mid-operation aborts it at the next edge: no Done, HI/LO cleared.
- Start accepted at edge k:
  - Busy = 1 after edges k .. k+32 (33 cycles).
  - HI/LO written and Done = 1 after edge k+33, with Busy = 0 in that same cycle.
  - A new Start is accepted at edge k+34 at the earliest; Done lasts exactly one cycle.
- Busy and Done are registered outputs. HI/LO are driven directly from registers, with no combinational path from the inputs.
- MTHI/MTLO latency: one edge.

## Configuration
- MDU_DIV_EN defined: the divide datapath is compiled in, and codes 10 and 13 behave as specified.
- MDU_DIV_EN undefined: the divide datapath is removed.
  - Start with code 10 or 13 is ignored: Busy stays 0, no Done pulse, HI/LO unchanged.
  - Multiply and mthi/mtlo behave identically to the defined case.

## Test plan
- multu: SrcA = 32'hFFFFFFFF, SrcB = 32'hFFFFFFFF -> Done after 34 cycles, HI = 32'hFFFFFFFE, LO = 32'h00000001.
- mult: SrcA = -7, SrcB = 3 -> HI = 32'hFFFFFFFF, LO = 32'hFFFFFFEB. Start pulsed again mid-CALC -> ignored, same result and timing.
- div: SrcA = -7, SrcB = 2 -> LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF. divu: 100 / 7 -> LO = 14, HI = 2.
- Divide by zero: divu 5 / 0 -> LO = 32'hFFFFFFFF, HI = 5. Signed overflow case -> LO = 32'h80000000, HI = 0.
- MTHI with SrcA = 32'h12345678 in IDLE -> HI updated next edge. MTLO asserted while Busy -> LO unchanged. RST low at CALC cycle 10 -> Busy = 0, HI = LO = 0, no Done.
- With MDU_DIV_EN undefined: Start with code 10 -> Busy never rises, HI/LO unchanged. Start with code 12 -> normal multiply.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers.
// Signed and unsigned multiply use 32 shift-add steps. Signed and unsigned
// divide use 32 restoring steps. Both work on operand magnitudes, and a
// single sign-fix cycle writes HI/LO.
// Build option: define MDU_DIV_EN to compile in the divide datapath. Without
// it, divide codes are ignored.
module mdu_hilo #(
    parameter int DATA_width       = 32,
    parameter int ALUControl_width = 5
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        Start,
    input  logic [ALUControl_width-1:0] ALUControl,
    input  logic [DATA_width-1:0]       SrcA,
    input  logic [DATA_width-1:0]       SrcB,
    input  logic                        MTHI,
    input  logic                        MTLO,
    output logic                        Busy,
    output logic                        Done,
    output logic [DATA_width-1:0]       HI,
    output logic [DATA_width-1:0]       LO
);
    localparam int W = DATA_width;
    localparam logic [ALUControl_width-1:0] OP_MULT  = ALUControl_width'(9);
    localparam logic [ALUControl_width-1:0] OP_MULTU = ALUControl_width'(12);
    localparam logic [ALUControl_width-1:0] OP_DIV   = ALUControl_width'(10);
`ifdef MDU_DIV_EN
    localparam logic [ALUControl_width-1:0] OP_DIVU  = ALUControl_width'(13);
`endif
    localparam logic [5:0] LAST_IT = 6'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Magnitude of an operand. For signed codes, the most-negative value maps
    // to 2^(W-1). That value is still exact when read as unsigned.
    function automatic logic [W-1:0] abs_val(input logic [W-1:0] v, input logic is_signed);
        return (is_signed && v[W-1]) ? -v : v;
    endfunction

    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*W-1:0] cond_neg_wide(input logic [2*W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Control state
    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    // Datapath state:
    //   multiply: acc = upper product word, low = multiplier, opb = multiplicand.
    //   divide:   acc = remainder,          low = dividend/quotient, opb = divisor.
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   low_q, low_d;
    logic [W-1:0]   opb_q, opb_d;
    logic           neg_lo_q, neg_lo_d;
`ifdef MDU_DIV_EN
    logic           is_div_q, is_div_d;
    logic           neg_hi_q, neg_hi_d;
    logic           dz_q, dz_d;
`endif

    logic           op_mul, op_div, op_signed, accept;
    logic [W:0]     mul_sum;
    logic [W-1:0]   mul_acc_nxt, mul_low_nxt;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   res_hi, res_lo;

    // Decode the request. Only the recognised codes start an operation, and only from IDLE.
    always_comb begin
        op_mul    = (ALUControl == OP_MULT) || (ALUControl == OP_MULTU);
`ifdef MDU_DIV_EN
        op_div    = (ALUControl == OP_DIV) || (ALUControl == OP_DIVU);
`else
        op_div    = 1'b0;
`endif
        op_signed = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
        accept    = Start && (state_q == S_IDLE) && (op_mul || op_div);
    end

    // One shift-add multiply step. The carry out of the add shifts down into the accumulator MSB.
    always_comb begin
        mul_sum     = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        mul_acc_nxt = mul_sum[W:1];
        mul_low_nxt = {mul_sum[0], low_q[W-1:1]};
    end

`ifdef MDU_DIV_EN
    logic [W:0]   div_shift;
    logic         div_ge;
    logic [W-1:0] div_diff, div_acc_nxt, div_low_nxt;

    // One restoring-divide step. The trial difference is kept only when it
    // is non-negative. The remainder is always below the divisor, so W bits
    // are enough to hold it.
    always_comb begin
        div_shift   = {acc_q, low_q[W-1]};
        div_ge      = div_shift >= {1'b0, opb_q};
        div_diff    = div_shift[W-1:0] - opb_q;
        div_acc_nxt = div_ge ? div_diff : div_shift[W-1:0];
        div_low_nxt = {low_q[W-2:0], div_ge};
    end
`endif

    // Sign-corrected result written in FIX.
    always_comb begin
        prod_fix = cond_neg_wide({acc_q, low_q}, neg_lo_q);
        res_hi   = prod_fix[2*W-1:W];
        res_lo   = prod_fix[W-1:0];
`ifdef MDU_DIV_EN
        // On divide by zero, the remainder path already reproduces the
        // dividend. Only the quotient is forced to all ones.
        if (is_div_q) begin
            res_hi = cond_neg(acc_q, neg_hi_q);
            res_lo = dz_q ? {W{1'b1}} : cond_neg(low_q, neg_lo_q);
        end
`endif
    end

    // Next-state and next-register logic for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        low_d    = low_q;
        opb_d    = opb_q;
        neg_lo_d = neg_lo_q;
`ifdef MDU_DIV_EN
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_CALC;
                    cnt_d    = 6'd0;
                    busy_d   = 1'b1;
                    acc_d    = '0;
                    neg_lo_d = op_signed && (SrcA[W-1] ^ SrcB[W-1]);
                    if (op_div) begin
                        low_d = abs_val(SrcA, op_signed);
                        opb_d = abs_val(SrcB, op_signed);
                    end else begin
                        low_d = abs_val(SrcB, op_signed);
                        opb_d = abs_val(SrcA, op_signed);
                    end
`ifdef MDU_DIV_EN
                    is_div_d = op_div;
                    neg_hi_d = op_signed && SrcA[W-1];
                    dz_d     = op_div && (SrcB == '0);
`endif
                end else begin
                    // Start takes priority over mthi/mtlo in the same cycle.
                    if (MTHI) hi_d = SrcA;
                    if (MTLO) lo_d = SrcA;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 6'd1;
                acc_d = mul_acc_nxt;
                low_d = mul_low_nxt;
`ifdef MDU_DIV_EN
                if (is_div_q) begin
                    acc_d = div_acc_nxt;
                    low_d = div_low_nxt;
                end
`endif
                if (cnt_q == LAST_IT) state_d = S_FIX;
            end
            S_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and architectural registers. Reset aborts any operation and clears HI/LO.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Datapath working registers. They are always reloaded on accept, so they need no reset.
    always_ff @(posedge CLK) begin
        acc_q    <= acc_d;
        low_q    <= low_d;
        opb_q    <= opb_d;
        neg_lo_q <= neg_lo_d;
`ifdef MDU_DIV_EN
        is_div_q <= is_div_d;
        neg_hi_q <= neg_hi_d;
        dz_q     <= dz_d;
`endif
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed and randomized checks of mdu_hilo against an
// arithmetic reference model of HI/LO.
module tb_mdu_hilo;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        Start;
    logic [4:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        MTHI;
    logic        MTLO;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_hilo #(.DATA_width(32), .ALUControl_width(5)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .MTHI(MTHI), .MTLO(MTLO),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit accepted(input logic [4:0] code);
        return (code == 5'd9) || (code == 5'd12) ||
               (DIV_EN && ((code == 5'd10) || (code == 5'd13)));
    endfunction

    // Reference results straight from the ISA definition of each operation.
    function automatic void model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        longint      sp;
        int          sa, sb;
        hi = '0;
        lo = '0;
        p  = '0;
        sa = a;
        sb = b;
        case (code)
            5'd9: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p  = sp;
                hi = p[63:32];
                lo = p[31:0];
            end
            5'd12: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            5'd10: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFFFFFF; hi = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    lo = 32'h80000000; hi = 32'h0;
                end else begin
                    lo = sa / sb; hi = sa % sb;
                end
            end
            5'd13: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFFFFFF; hi = a;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
            default: begin
                hi = '0; lo = '0;
            end
        endcase
    endfunction

    // Issue one Start. Optionally pulse Start again mid-CALC (pulse_mid),
    // poke MTHI/MTLO while busy (mt_mid), or poke MTHI/MTLO together with
    // Start (mt_same).
    task automatic do_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                         input logic [31:0] b, input bit pulse_mid, input bit mt_mid, input bit mt_same);
        logic [31:0] eh, el;
        bit acc, bad;
        acc = accepted(code);
        model(code, a, b, eh, el);
        ALUControl = code; SrcA = a; SrcB = b; Start = 1'b1;
        MTHI = mt_same; MTLO = mt_same;
        @(posedge CLK); #1;
        Start = 1'b0; MTHI = 1'b0; MTLO = 1'b0; ALUControl = 5'd0;
        if (acc) begin
            check({tag, "_busy_on_accept"}, 32'(Busy), 32'd1);
            check({tag, "_hilo_on_accept"}, HI ^ LO, m_hi ^ m_lo);
            bad = 1'b0;
            for (int n = 1; n <= 32; n++) begin
                if (pulse_mid && n == 5) begin
                    Start = 1'b1; ALUControl = 5'd12; SrcA = $urandom; SrcB = $urandom;
                end
                if (mt_mid && n == 7) begin
                    MTHI = 1'b1; MTLO = 1'b1; SrcA = 32'hDEADBEEF;
                end
                @(posedge CLK); #1;
                Start = 1'b0; MTHI = 1'b0; MTLO = 1'b0; ALUControl = 5'd0;
                if (Busy !== 1'b1 || Done !== 1'b0 || HI !== m_hi || LO !== m_lo) bad = 1'b1;
            end
            check({tag, "_calc_window"}, 32'(bad), 32'd0);
            @(posedge CLK); #1;
            check({tag, "_done"}, 32'(Done), 32'd1);
            check({tag, "_busy_at_done"}, 32'(Busy), 32'd0);
            check({tag, "_hi"}, HI, eh);
            check({tag, "_lo"}, LO, el);
            m_hi = eh; m_lo = el;
            @(posedge CLK); #1;
            check({tag, "_done_one_cycle"}, 32'(Done), 32'd0);
        end else begin
            bad = 1'b0;
            for (int n = 0; n < 40; n++) begin
                if (Busy !== 1'b0 || Done !== 1'b0 || HI !== m_hi || LO !== m_lo) bad = 1'b1;
                @(posedge CLK); #1;
            end
            check({tag, "_ignored"}, 32'(bad), 32'd0);
        end
    endtask

    task automatic do_mt(input string tag, input bit hw, input bit lw, input logic [31:0] d);
        MTHI = hw; MTLO = lw; SrcA = d;
        @(posedge CLK); #1;
        MTHI = 1'b0; MTLO = 1'b0;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
        check({tag, "_hi"}, HI, m_hi);
        check({tag, "_lo"}, LO, m_lo);
    endtask

    task automatic reset_mid_calc();
        bit bad;
        ALUControl = 5'd12; SrcA = 32'h0BADF00D; SrcB = 32'h00001234; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        m_hi = '0; m_lo = '0;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        bad = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge CLK); #1;
            if (Busy !== 1'b0 || Done !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad = 1'b1;
        end
        check("abort_no_done", 32'(bad), 32'd0);
    endtask

    initial begin
        logic [4:0]  rcode;
        logic [31:0] ra, rb;
        int          sel;

        RST = 1'b0; Start = 1'b0; ALUControl = 5'd0; SrcA = '0; SrcB = '0; MTHI = 1'b0; MTLO = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;

        do_op("multu_max", 5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        check("multu_max_hi_const", HI, 32'hFFFFFFFE);
        check("multu_max_lo_const", LO, 32'h00000001);

        do_op("mult_neg", 5'd9, 32'hFFFFFFF9, 32'd3, 1'b1, 1'b0, 1'b0);
        check("mult_neg_hi_const", HI, 32'hFFFFFFFF);
        check("mult_neg_lo_const", LO, 32'hFFFFFFEB);

        do_mt("mthi", 1'b1, 1'b0, 32'h12345678);
        do_mt("mtlo", 1'b0, 1'b1, 32'hCAFEF00D);
        do_mt("mtboth", 1'b1, 1'b1, 32'h5A5A1234);

        do_op("mt_while_busy", 5'd12, 32'h00012345, 32'h00006789, 1'b0, 1'b1, 1'b0);
        do_op("mt_with_start", 5'd9, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1);

`ifdef MDU_DIV_EN
        do_op("div_neg", 5'd10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        check("div_neg_lo_const", LO, 32'hFFFFFFFD);
        check("div_neg_hi_const", HI, 32'hFFFFFFFF);
        do_op("divu", 5'd13, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        check("divu_lo_const", LO, 32'd14);
        check("divu_hi_const", HI, 32'd2);
        do_op("divu_zero", 5'd13, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
        check("divu_zero_lo_const", LO, 32'hFFFFFFFF);
        check("divu_zero_hi_const", HI, 32'd5);
        do_op("div_ovf", 5'd10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        check("div_ovf_lo_const", LO, 32'h80000000);
        check("div_ovf_hi_const", HI, 32'd0);
        do_op("div_zero_neg", 5'd10, 32'hFFFFFFFB, 32'd0, 1'b0, 1'b0, 1'b0);
`else
        do_op("div_disabled", 5'd10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        do_op("divu_disabled", 5'd13, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        do_op("multu_no_div", 5'd12, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
`endif
        do_op("bad_code_11", 5'd11, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
        do_op("bad_code_0", 5'd0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);

        do_mt("pre_abort", 1'b1, 1'b1, 32'h77778888);
        reset_mid_calc();

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 6);
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) begin
                ra = 32'h80000000; rb = 32'hFFFFFFFF;
            end
            case (sel)
                0: rcode = 5'd9;
                1: rcode = 5'd12;
                2: rcode = 5'd10;
                3: rcode = 5'd13;
                default: rcode = 5'd11;
            endcase
            if (sel >= 5) do_mt("rand_mt", sel == 5, 1'b1, ra);
            else do_op("rand_op", rcode, ra, rb, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
